// File: rtl/jsilicon_pkg.sv
// Shared types and UART frame constants for the Jsilicon compute core.
package jsilicon_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_CMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  // Result width is twice the operand width, rounded up to whole bytes.
  function automatic int unsigned result_width(input int unsigned data_w);
    return ((2 * data_w + 7) / 8) * 8;
  endfunction

endpackage

// File: rtl/jsilicon_core_v2_if.sv
// Request/result/UART bundle of jsilicon_core_v2; master drives requests, slave is the core.
interface jsilicon_core_v2_if #(
  parameter int unsigned DATA_W = 8
);
  import jsilicon_pkg::*;

  localparam int unsigned RESULT_W = result_width(DATA_W);

  logic                start;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic [2:0]          opcode;
  logic                busy;
  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic                done;
  logic                tx;

  modport master (
    output start, a, b, opcode,
    input  busy, result, result_valid, done, tx
  );

  modport slave (
    input  start, a, b, opcode,
    output busy, result, result_valid, done, tx
  );

endinterface

// File: rtl/jsilicon_uart_tx.sv
// Byte-wide UART transmitter, CLK_DIV clocks per bit, idle-high line.
// Define JSILICON_UART_PARITY_EN to append an even-parity bit before the stop bit.
module jsilicon_uart_tx
  import jsilicon_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 tx,
  output logic                 last_c
);

`ifdef JSILICON_UART_PARITY_EN
  localparam int unsigned FRAME = DATA_BITS + 3;
`else
  localparam int unsigned FRAME = DATA_BITS + 2;
`endif
  localparam int unsigned SH_W  = FRAME - 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME);

  logic [SH_W-1:0]  shift_q;
  logic [SH_W-1:0]  frame_c;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic             bit_end_c;

  // Bits following the start bit, LSB first from shift_q[0].
`ifdef JSILICON_UART_PARITY_EN
  assign frame_c = {STOP_BIT, ^data, data};
`else
  assign frame_c = {STOP_BIT, data};
`endif

  assign bit_end_c = busy && (div_q == DIV_W'(CLK_DIV - 1));
  assign last_c    = bit_end_c && (bit_q == BIT_W'(FRAME - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      tx      <= STOP_BIT;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
    end else if (!busy) begin
      if (load) begin
        busy    <= 1'b1;
        tx      <= START_BIT;
        shift_q <= frame_c;
        div_q   <= '0;
        bit_q   <= '0;
      end
    end else if (bit_end_c) begin
      div_q <= '0;
      if (last_c) begin
        busy  <= 1'b0;
        tx    <= STOP_BIT;
        bit_q <= '0;
      end else begin
        bit_q   <= bit_q + BIT_W'(1);
        tx      <= shift_q[0];
        shift_q <= shift_q >> 1;
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/jsilicon_core_v2.sv
// Jsilicon compute core: start/busy handshake, ALU, result sent LSB byte first over UART.
// Build option JSILICON_UART_PARITY_EN adds an even-parity bit to every frame.
module jsilicon_core_v2
  import jsilicon_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  jsilicon_core_v2_if.slave bus
);

  localparam int unsigned RESULT_W = result_width(DATA_W);
  localparam int unsigned NBYTES   = RESULT_W / DATA_BITS;
  localparam int unsigned IDX_W    = 2;

  state_e              state_q, state_n;
  logic [DATA_W-1:0]   a_q, b_q;
  opcode_e             op_q;
  logic [RESULT_W-1:0] result_q, alu_c, a_ext, b_ext;
  logic                result_valid_q, busy_q, done_q;
  logic [IDX_W-1:0]    byte_idx_q;
  logic                accept_c, exec_c, load_c, next_byte_c, last_byte_c;
  logic                tx_busy, tx_last_c, tx_line;
  logic [7:0]          tx_byte_c;

  assign last_byte_c = (byte_idx_q == IDX_W'(NBYTES - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_n = S_EXEC;
      S_EXEC:  state_n = S_LOAD;
      S_LOAD:  state_n = S_SEND;
      S_SEND:  if (tx_last_c) state_n = last_byte_c ? S_FIN : S_LOAD;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    accept_c    = 1'b0;
    exec_c      = 1'b0;
    load_c      = 1'b0;
    next_byte_c = 1'b0;
    case (state_q)
      S_IDLE:  accept_c    = bus.start;
      S_EXEC:  exec_c      = 1'b1;
      S_LOAD:  load_c      = !tx_busy;
      S_SEND:  next_byte_c = tx_last_c && !last_byte_c;
      default: ;
    endcase
  end

  // Operands are zero-extended; every op wraps modulo 2^RESULT_W.
  always_comb begin
    a_ext = RESULT_W'(a_q);
    b_ext = RESULT_W'(b_q);
    alu_c = '0;
    case (op_q)
      OP_ADD: alu_c = a_ext + b_ext;
      OP_SUB: alu_c = a_ext - b_ext;
      OP_MUL: alu_c = a_ext * b_ext;
      OP_AND: alu_c = a_ext & b_ext;
      OP_OR:  alu_c = a_ext | b_ext;
      OP_XOR: alu_c = a_ext ^ b_ext;
      OP_SHL: alu_c = a_ext << b_q[3:0];
      OP_CMP: alu_c = RESULT_W'({a_q > b_q, a_q == b_q, a_q < b_q});
      default: alu_c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= OP_ADD;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      byte_idx_q     <= '0;
    end else begin
      busy_q <= (state_n != S_IDLE);
      done_q <= (state_n == S_FIN);
      if (accept_c) begin
        a_q            <= bus.a;
        b_q            <= bus.b;
        op_q           <= opcode_e'(bus.opcode);
        result_valid_q <= 1'b0;
        byte_idx_q     <= '0;
      end
      if (exec_c) begin
        result_q       <= alu_c;
        result_valid_q <= 1'b1;
      end
      if (next_byte_c) byte_idx_q <= byte_idx_q + IDX_W'(1);
    end
  end

  assign tx_byte_c = 8'(result_q >> {byte_idx_q, 3'b000});

  jsilicon_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load_c),
    .data    (tx_byte_c),
    .busy    (tx_busy),
    .tx      (tx_line),
    .last_c  (tx_last_c)
  );

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.done         = done_q;
  assign bus.tx           = tx_line;

endmodule

// File: tb/tb_jsilicon_core_v2.sv
// Scoreboard bench for jsilicon_core_v2 (DATA_W=8, CLK_DIV=4); honours JSILICON_UART_PARITY_EN.
module tb_jsilicon_core_v2;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NB      = 2;
`ifdef JSILICON_UART_PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif
  localparam int unsigned EXP_LEN = 2 + NB * (FRAME * CLK_DIV + 1) + 1;

  logic clock;
  logic reset_n;

  jsilicon_core_v2_if #(.DATA_W(DATA_W)) bus ();

  jsilicon_core_v2 #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_res_q[$];
  logic [15:0] exp_done_q[$];
  logic [7:0]  exp_byte_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no expected entry or bound expired", name);
  endtask

  // Result monitor: each rising result_valid consumes one expected result.
  initial begin
    logic rv_prev;
    rv_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.result_valid === 1'b1 && !rv_prev) begin
        if (exp_res_q.size() == 0) fail_msg("result_unexpected");
        else chk("result", 32'(bus.result), 32'(exp_res_q.pop_front()));
      end
      rv_prev = (bus.result_valid === 1'b1);
    end
  end

  // Done monitor: each done cycle consumes one expected completion.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        if (exp_done_q.size() == 0) fail_msg("done_unexpected");
        else chk("done_result", 32'(bus.result), 32'(exp_done_q.pop_front()));
      end
    end
  end

  // UART monitor: decodes frames at bit centres, checks framing and byte order.
  initial begin
    bit         active;
    int         cyc;
    int         bi;
    logic [7:0] data;
    active = 1'b0;
    cyc    = 0;
    data   = '0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (bus.tx === 1'b0) begin
          active = 1'b1;
          cyc    = 0;
          data   = '0;
        end
      end else begin
        cyc++;
      end
      if (active && (cyc % CLK_DIV == CLK_DIV / 2)) begin
        bi = cyc / CLK_DIV;
        if (bi == 0) begin
          chk("start_bit", 32'(bus.tx), 32'(0));
        end else if (bi <= 8) begin
          data[bi-1] = bus.tx;
        end else if (bi == FRAME - 1) begin
          chk("stop_bit", 32'(bus.tx), 32'(1));
          if (exp_byte_q.size() == 0) fail_msg("frame_unexpected");
          else chk("tx_byte", 32'(data), 32'(exp_byte_q.pop_front()));
        end else begin
          chk("parity_bit", 32'(bus.tx), 32'(^data));
        end
      end
      if (active && cyc == FRAME * CLK_DIV) begin
        chk("frame_len_idle", 32'(bus.tx), 32'(1));
        active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op, push its expectations, and time the busy window.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] res, input int poke_at, input bit hold);
    int guard;
    int hi;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 5000) fail_msg("idle_timeout");
    exp_res_q.push_back(res);
    exp_done_q.push_back(res);
    for (int i = 0; i < NB; i++) exp_byte_q.push_back(8'(res >> (8 * i)));
    bus.a      = a;
    bus.b      = b;
    bus.opcode = op;
    bus.start  = 1'b1;
    @(negedge clock);
    if (!hold) bus.start = 1'b0;
    chk("busy_after_accept", 32'(bus.busy), 32'(1));
    chk("rv_cleared", 32'(bus.result_valid), 32'(0));
    @(negedge clock);
    chk("rv_latency", 32'(bus.result_valid), 32'(1));
    hi = 2;
    forever begin
      @(negedge clock);
      if (bus.busy !== 1'b1 || hi > 5000) break;
      hi++;
      if (poke_at != 0 && hi == poke_at && !hold) begin
        bus.a     = 8'h11;
        bus.start = 1'b1;
      end else if (!hold) begin
        bus.start = 1'b0;
      end
    end
    chk("busy_len", 32'(hi + 1), 32'(EXP_LEN));
    chk("result_hold", 32'(bus.result), 32'(res));
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.opcode = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_rv", 32'(bus.result_valid), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_tx", 32'(bus.tx), 32'(1));
    reset_n = 1'b1;
    @(negedge clock);

    do_op(3'b000, 8'hFF, 8'h01, 16'h0100, 0, 1'b0);
    do_op(3'b001, 8'h03, 8'h05, 16'hFFFE, 0, 1'b0);
    do_op(3'b010, 8'h0F, 8'h0F, 16'h00E1, 0, 1'b0);
    do_op(3'b110, 8'h81, 8'h04, 16'h0810, 0, 1'b0);
    do_op(3'b110, 8'hFF, 8'h1F, 16'h8000, 0, 1'b0);
    do_op(3'b111, 8'h05, 8'h05, 16'h0002, 0, 1'b0);
    do_op(3'b111, 8'h02, 8'h07, 16'h0001, 0, 1'b0);
    do_op(3'b111, 8'h07, 8'h02, 16'h0004, 0, 1'b0);
    do_op(3'b000, 8'h01, 8'h02, 16'h0003, 0, 1'b0);
    do_op(3'b011, 8'hF0, 8'h3C, 16'h0030, 0, 1'b0);
    do_op(3'b100, 8'hF0, 8'h0F, 16'h00FF, 0, 1'b0);
    do_op(3'b101, 8'hFF, 8'h0F, 16'h00F0, 20, 1'b0);

    // start held through FIN: the second op is taken on the first idle cycle.
    do_op(3'b000, 8'h10, 8'h20, 16'h0030, 0, 1'b1);
    do_op(3'b001, 8'h20, 8'h10, 16'h0010, 0, 1'b0);

    // Reset during data bit 3 of byte 0 abandons the op.
    exp_res_q.push_back(16'h0100);
    bus.a      = 8'hFF;
    bus.b      = 8'h01;
    bus.opcode = 3'b000;
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (19) @(negedge clock);
    chk("pre_reset_busy", 32'(bus.busy), 32'(1));
    chk("pre_reset_tx_bit3", 32'(bus.tx), 32'(0));
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_tx", 32'(bus.tx), 32'(1));
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_rv", 32'(bus.result_valid), 32'(0));
    chk("abort_result", 32'(bus.result), 32'(0));
    reset_n = 1'b1;
    @(negedge clock);
    do_op(3'b010, 8'h10, 8'h10, 16'h0100, 0, 1'b0);

    repeat (5) @(negedge clock);
    chk("bytes_left", 32'(exp_byte_q.size()), 32'(0));
    chk("done_left", 32'(exp_done_q.size()), 32'(0));
    chk("results_left", 32'(exp_res_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
